// File: rtl/packet_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : packet_rr_arbiter
// Description : Packet-level round-robin arbiter feeding one Avalon-ST stream.
//               The grant is held from SOP to EOP, so packets never interleave.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_rr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 128
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]                in_data,
  input  logic [NUM_SRC-1:0]                           in_valid,
  input  logic [NUM_SRC-1:0]                           in_sop,
  input  logic [NUM_SRC-1:0]                           in_eop,
  input  logic [NUM_SRC*$clog2(DATA_WIDTH/8)-1:0]      in_empty,
  output logic [NUM_SRC-1:0]                           in_ready,
  output logic [DATA_WIDTH-1:0]                        out_data,
  output logic                                         out_valid,
  output logic                                         out_sop,
  output logic                                         out_eop,
  output logic [$clog2(DATA_WIDTH/8)-1:0]              out_empty,
  output logic [$clog2(NUM_SRC)-1:0]                   out_channel,
  input  logic                                         out_ready,
  output logic                                         err_no_sop
);

  localparam int c_CH_W    = $clog2(NUM_SRC);
  localparam int c_EMPTY_W = $clog2(DATA_WIDTH/8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CH_W-1:0]   r_grant;
  logic [c_CH_W-1:0]   r_rr_ptr;
  logic                r_first;

  logic                w_busy;
  logic                w_xfer;
  logic                w_found;
  logic [c_CH_W-1:0]   w_pick;
  logic [c_CH_W:0]     w_scan_idx;
  logic [c_CH_W-1:0]   w_next_ptr;

  assign w_busy      = (r_state == BUSY);
  assign out_valid   = w_busy & in_valid[r_grant];
  assign out_data    = out_valid ? in_data[r_grant*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign out_sop     = out_valid & in_sop[r_grant];
  assign out_eop     = out_valid & in_eop[r_grant];
  assign out_empty   = out_eop ? in_empty[r_grant*c_EMPTY_W +: c_EMPTY_W] : '0;
  assign out_channel = r_grant;
  assign w_xfer      = out_valid & out_ready;

  always_comb begin
    in_ready = '0;
    if (w_busy) begin
      in_ready[r_grant] = out_ready;
    end
  end

  // Scan starts at rr_ptr; the one-bit-wider index lets non-power-of-two
  // source counts wrap correctly.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_scan_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_scan_idx = {1'b0, r_rr_ptr} + (c_CH_W+1)'(i);
      if (w_scan_idx >= (c_CH_W+1)'(NUM_SRC)) begin
        w_scan_idx = w_scan_idx - (c_CH_W+1)'(NUM_SRC);
      end
      if (!w_found && in_valid[w_scan_idx[c_CH_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_scan_idx[c_CH_W-1:0];
      end
    end
  end

  assign w_next_ptr = (r_grant == c_CH_W'(NUM_SRC-1)) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_first    <= 1'b0;
      err_no_sop <= 1'b0;
    end else begin
      err_no_sop <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|in_valid) begin
            r_state <= ARB;
          end
        end
        ARB: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_first <= 1'b1;
            r_state <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (w_xfer) begin
            r_first    <= 1'b0;
            err_no_sop <= r_first & ~out_sop;
            if (out_eop) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_packet_rr_arbiter
// Description : Directed self-checking bench for packet_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_rr_arbiter;

  localparam int NUM_SRC    = 4;
  localparam int DATA_WIDTH = 128;
  localparam int EW         = $clog2(DATA_WIDTH/8);
  localparam int CW         = $clog2(NUM_SRC);

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NUM_SRC*DATA_WIDTH-1:0] in_data;
  logic [NUM_SRC-1:0]            in_valid, in_sop, in_eop, in_ready;
  logic [NUM_SRC*EW-1:0]         in_empty;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_valid, out_sop, out_eop, out_ready, err_no_sop;
  logic [EW-1:0]                 out_empty;
  logic [CW-1:0]                 out_channel;

  int checks = 0;
  int errors = 0;

  // Per-source packet generator state
  int         src_len   [NUM_SRC];
  int         src_beat  [NUM_SRC];
  int         src_pkt   [NUM_SRC];
  int         src_limit [NUM_SRC];
  logic [EW-1:0] src_empty [NUM_SRC];
  logic       src_nosop [NUM_SRC];
  logic       src_hold  [NUM_SRC];

  packet_rr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_channel(out_channel), .out_ready(out_ready),
    .err_no_sop(err_no_sop)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_WIDTH-1:0] beat_word(int s, int p, int b);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[31:0]    = {8'hA5, 8'(s), 8'(p), 8'(b)};
    w[127:96]  = 32'hC0DE_0000 | 32'(s);
    return w;
  endfunction

  task automatic apply_inputs();
    for (int s = 0; s < NUM_SRC; s++) begin
      logic act;
      act = (src_len[s] > 0) && (src_pkt[s] < src_limit[s]);
      in_valid[s] = act && !src_hold[s];
      in_sop[s]   = act && (src_beat[s] == 0) && !src_nosop[s];
      in_eop[s]   = act && (src_beat[s] == src_len[s] - 1);
      in_data[s*DATA_WIDTH +: DATA_WIDTH] = act ? beat_word(s, src_pkt[s], src_beat[s]) : '0;
      in_empty[s*EW +: EW] = src_empty[s];
    end
  endtask

  task automatic clear_sources();
    for (int s = 0; s < NUM_SRC; s++) begin
      src_len[s] = 0; src_beat[s] = 0; src_pkt[s] = 0; src_limit[s] = 1000;
      src_empty[s] = '0; src_nosop[s] = 1'b0; src_hold[s] = 1'b0;
    end
    apply_inputs();
  endtask

  // Call just before the rising edge; advances any source whose beat is accepted.
  task automatic tick();
    logic [NUM_SRC-1:0] x;
    x = in_valid & in_ready;
    @(posedge clk); #1;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (x[s]) begin
        if (src_beat[s] == src_len[s] - 1) begin
          src_beat[s] = 0; src_pkt[s]++; src_nosop[s] = 1'b0;
        end else begin
          src_beat[s]++;
        end
      end
    end
    apply_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_sources();
    for (int s = 0; s < NUM_SRC; s++) src_len[s] = 2;
    apply_inputs();
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (err_no_sop !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_no_sop); end
    checks++; if (out_channel !== '0) begin errors++; $display("FAIL rst_channel got %0d exp 0", out_channel); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== '0) begin errors++; $display("FAIL rst_arb_bubble valid %b ready %b exp 0 0", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_first_valid got %b exp 1", out_valid); end
    checks++; if (out_channel !== CW'(0) || out_sop !== 1'b1) begin errors++; $display("FAIL rst_first_grant ch %0d sop %b exp 0 1", out_channel, out_sop); end
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_ready got %b exp 0001", in_ready); end
    checks++; if (out_data !== beat_word(0, 0, 0)) begin errors++; $display("FAIL rst_first_data got %h exp %h", out_data, beat_word(0, 0, 0)); end
    // asynchronous reset mid-packet, observed before the next clock edge
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== '0) begin errors++; $display("FAIL async_reset valid %b ready %b exp 0 0", out_valid, in_ready); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int k, es, eb, ep;
    clear_sources();
    for (int s = 0; s < NUM_SRC; s++) begin src_len[s] = 3; src_empty[s] = EW'(s + 1); end
    apply_inputs();
    do_reset();
    k = 0;
    for (int c = 0; c < 120 && k < 15; c++) begin
      if (out_valid && out_ready) begin
        es = order[k/3]; eb = k % 3; ep = (k/3) / 4;
        checks++; if (out_channel !== CW'(es)) begin errors++; $display("FAIL rr_channel beat %0d got %0d exp %0d", k, out_channel, es); end
        checks++; if (out_data !== beat_word(es, ep, eb)) begin errors++; $display("FAIL rr_data beat %0d got %h exp %h", k, out_data, beat_word(es, ep, eb)); end
        checks++; if (out_sop !== (eb == 0) || out_eop !== (eb == 2)) begin errors++; $display("FAIL rr_framing beat %0d sop %b eop %b", k, out_sop, out_eop); end
        checks++; if (out_empty !== ((eb == 2) ? EW'(es + 1) : EW'(0))) begin errors++; $display("FAIL rr_empty beat %0d got %0d", k, out_empty); end
        checks++; if (in_ready !== (NUM_SRC'(1) << es)) begin errors++; $display("FAIL rr_ready beat %0d got %b", k, in_ready); end
        k++;
      end else if (!out_valid) begin
        checks++; if (out_data !== '0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_empty !== '0) begin errors++; $display("FAIL idle_zero data %h sop %b eop %b empty %0d exp all 0", out_data, out_sop, out_eop, out_empty); end
      end
      checks++; if (err_no_sop !== 1'b0) begin errors++; $display("FAIL rr_err got 1 exp 0"); end
      tick();
      @(negedge clk);
    end
    checks++; if (k !== 15) begin errors++; $display("FAIL rr_timeout beats %0d exp 15", k); end
  endtask

  task automatic test_wrap();
    int eops;
    bit done;
    clear_sources();
    src_len[2] = 2;
    apply_inputs();
    do_reset();
    eops = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (out_valid && out_ready) begin
        if (eops < 2) begin
          checks++; if (out_channel !== CW'(2)) begin errors++; $display("FAIL wrap_grant2 got %0d exp 2", out_channel); end
          if (out_eop) begin
            eops++;
            if (eops == 2) src_len[3] = 2;
          end
        end else begin
          checks++; if (out_channel !== CW'(3) || out_data !== beat_word(3, 0, 0)) begin errors++; $display("FAIL wrap_ptr3 ch %0d data %h exp 3 %h", out_channel, out_data, beat_word(3, 0, 0)); end
          done = 1;
        end
      end
      tick();
      @(negedge clk);
    end
    checks++; if (!done) begin errors++; $display("FAIL wrap_timeout eops %0d exp 2 then src3", eops); end
  endtask

  task automatic test_backpressure();
    int  k1;
    bit  got0;
    clear_sources();
    src_len[1] = 6; src_len[0] = 2; src_limit[0] = 0;
    apply_inputs();
    do_reset();
    k1 = 0; got0 = 0;
    for (int c = 0; c < 150 && !got0; c++) begin
      if (out_valid && out_ready) begin
        if (k1 < 6) begin
          checks++; if (out_channel !== CW'(1) || out_data !== beat_word(1, 0, k1)) begin errors++; $display("FAIL bp_src1 beat %0d ch %0d data %h", k1, out_channel, out_data); end
          if (k1 == 0) src_limit[0] = 1;
          k1++;
        end else begin
          checks++; if (out_channel !== CW'(0) || out_data !== beat_word(0, 0, 0) || out_sop !== 1'b1) begin errors++; $display("FAIL bp_src0 ch %0d data %h exp 0 %h", out_channel, out_data, beat_word(0, 0, 0)); end
          got0 = 1;
        end
      end
      if (k1 < 6) begin
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_preempt in_ready0 got 1 exp 0"); end
      end
      tick();
      out_ready   = ((c + 1) % 2 == 0);
      src_hold[1] = ((c + 1) % 3 == 2) && (k1 < 6);
      apply_inputs();
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++; if (!got0 || k1 !== 6) begin errors++; $display("FAIL bp_timeout src1 beats %0d exp 6 src0 %0d exp 1", k1, got0); end
  endtask

  task automatic test_single_beat();
    bit seen;
    clear_sources();
    src_len[3] = 1; src_empty[3] = EW'(5); src_limit[3] = 1;
    apply_inputs();
    do_reset();
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_valid && out_ready) begin
        checks++; if (out_sop !== 1'b1 || out_eop !== 1'b1) begin errors++; $display("FAIL sb_framing sop %b eop %b exp 1 1", out_sop, out_eop); end
        checks++; if (out_empty !== EW'(5)) begin errors++; $display("FAIL sb_empty got %0d exp 5", out_empty); end
        checks++; if (out_data !== beat_word(3, 0, 0)) begin errors++; $display("FAIL sb_data got %h exp %h", out_data, beat_word(3, 0, 0)); end
        seen = 1;
      end
      tick();
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL sb_timeout no beat seen"); end
    checks++; if (out_valid !== 1'b0 || in_ready !== '0 || out_empty !== '0) begin errors++; $display("FAIL sb_idle valid %b ready %b empty %0d exp 0", out_valid, in_ready, out_empty); end
  endtask

  task automatic test_no_sop();
    int pulses;
    bit fwd;
    clear_sources();
    src_len[1] = 2; src_nosop[1] = 1'b1;
    apply_inputs();
    do_reset();
    pulses = 0; fwd = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_ready && !fwd) begin
        checks++; if (out_sop !== 1'b0 || out_data !== beat_word(1, 0, 0)) begin errors++; $display("FAIL nosop_forward sop %b data %h exp 0 %h", out_sop, out_data, beat_word(1, 0, 0)); end
        fwd = 1;
      end
      if (err_no_sop === 1'b1) pulses++;
      tick();
      @(negedge clk);
    end
    checks++; if (!fwd) begin errors++; $display("FAIL nosop_timeout no beat forwarded"); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL nosop_pulse got %0d cycles exp 1", pulses); end
  endtask

  initial begin
    out_ready = 1'b1;
    clear_sources();
    test_reset();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_single_beat();
    test_no_sop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
